// File: rtl/lab_06_serializer.sv
// Parallel-to-serial stage feeding the lab 06 sequence detector's `a` input.
// Optional even-parity trailer bit is enabled by defining LAB06_SER_PARITY_EN.
module lab_06_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

`ifdef LAB06_SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    // cnt_q counts bits already placed on `a`; reaching FRAME-1 means the next bit is the last.
    localparam logic [CW-1:0] CNT_LAST_M1 = CW'(FRAME - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
`ifdef LAB06_SER_PARITY_EN
    localparam logic [CW-1:0] CNT_PARITY  = CW'(WIDTH);
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             a_valid_q, a_valid_d;
    logic             done_q, done_d;
`ifdef LAB06_SER_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef LAB06_SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            done_q    <= done_d;
`ifdef LAB06_SER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // done_q marks the last frame bit on `a`, which is exactly the reload window.
    assign load_ready = (state_q == IDLE) || done_q;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (done_q && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d       = 1'b0;
        a_valid_d = 1'b0;
        done_d    = 1'b0;
        sr_d      = '0;
        cnt_d     = '0;
`ifdef LAB06_SER_PARITY_EN
        par_d     = 1'b0;
`endif
        if (accept) begin
            a_valid_d = 1'b1;
            cnt_d     = CNT_ONE;
            if (MSB_FIRST) begin
                a_d  = din[WIDTH-1];
                sr_d = din << 1;
            end else begin
                a_d  = din[0];
                sr_d = din >> 1;
            end
`ifdef LAB06_SER_PARITY_EN
            par_d = ^din;
`endif
        end else if ((state_q == SHIFT) && !done_q) begin
            a_valid_d = 1'b1;
            cnt_d     = cnt_q + CNT_ONE;
            done_d    = (cnt_q == CNT_LAST_M1);
            if (MSB_FIRST) begin
                a_d  = sr_q[WIDTH-1];
                sr_d = sr_q << 1;
            end else begin
                a_d  = sr_q[0];
                sr_d = sr_q >> 1;
            end
`ifdef LAB06_SER_PARITY_EN
            par_d = par_q;
            if (cnt_q == CNT_PARITY) a_d = par_q;
`endif
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;
    assign done    = done_q;
    assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_lab_06_serializer.sv
// Scoreboard bench for lab_06_serializer: MSB-first and LSB-first instances share one producer.
// Define LAB06_SER_PARITY_EN for both RTL and bench to exercise the parity trailer.
module tb_lab_06_serializer;

    localparam int W = 8;
`ifdef LAB06_SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int F = PAR ? W + 1 : W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] din = '0;

    logic rdy_m, a_m, av_m, bz_m, dn_m;
    logic rdy_l, a_l, av_l, bz_l, dn_l;

    always #5 clk = ~clk;

    lab_06_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(rdy_m), .a(a_m), .a_valid(av_m), .busy(bz_m), .done(dn_m)
    );

    lab_06_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(rdy_l), .a(a_l), .a_valid(av_l), .busy(bz_l), .done(dn_l)
    );

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q [2][$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Expected frame: data bits in line order, then optional even parity; the final bit is flagged last.
    task automatic push_word(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            q[0].push_back('{b: d[W-1-i], last: (!PAR && i == W-1)});
            q[1].push_back('{b: d[i],     last: (!PAR && i == W-1)});
        end
        if (PAR) begin
            q[0].push_back('{b: ^d, last: 1'b1});
            q[1].push_back('{b: ^d, last: 1'b1});
        end
    endtask

    task automatic mon(input int k, input string tag, input logic a_s, input logic av_s,
                       input logic bz_s, input logic dn_s, input logic rd_s);
        exp_t e;
        if (q[k].size() > 0) begin
            e = q[k].pop_front();
            chk({tag, "_a_valid"}, av_s, 1'b1);
            chk({tag, "_a"},       a_s,  e.b);
            chk({tag, "_done"},    dn_s, e.last);
            chk({tag, "_busy"},    bz_s, 1'b1);
            chk({tag, "_ready"},   rd_s, e.last);
        end else begin
            chk({tag, "_idle_a_valid"}, av_s, 1'b0);
            chk({tag, "_idle_a"},       a_s,  1'b0);
            chk({tag, "_idle_done"},    dn_s, 1'b0);
            chk({tag, "_idle_busy"},    bz_s, 1'b0);
            chk({tag, "_idle_ready"},   rd_s, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, "msb", a_m, av_m, bz_m, dn_m, rdy_m);
            mon(1, "lsb", a_l, av_l, bz_l, dn_l, rdy_l);
        end
    end

    // Inputs for the next rising edge; acceptance follows the model's own notion of readiness.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit rst, output bit acc);
        @(negedge clk);
        #2;
        reset      = rst;
        load_valid = v;
        din        = d;
        acc        = 1'b0;
        if (rst) begin
            q[0].delete();
            q[1].delete();
        end else if (v && q[0].size() == 0) begin
            push_word(d);
            acc = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), 1'b0, acc);
    endtask

    task automatic hold(input logic [W-1:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 2 * F + 2 && !acc; i++) drive(1'b1, d, 1'b0, acc);
    endtask

    initial begin
        bit           acc;
        bit           pending;
        logic [W-1:0] held;

        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        drive(1'b0, '0, 1'b0, acc);

        drive(1'b1, 8'hB4, 1'b0, acc);
        idle(F + 2);

        drive(1'b1, 8'hFF, 1'b0, acc);
        hold(8'h00);
        idle(F + 2);

        drive(1'b1, 8'hA5, 1'b0, acc);
        idle(2);
        hold(8'h3C);
        idle(F + 2);

        // din churns while the frame is in flight; none of it may leak into the line.
        drive(1'b1, 8'h5A, 1'b0, acc);
        for (int i = 0; i < F - 1; i++) drive(1'b1, W'($urandom), 1'b0, acc);
        idle(F + 2);

        drive(1'b1, 8'h6D, 1'b0, acc);
        idle(3);
        drive(1'b0, '0, 1'b1, acc);
        idle(2);
        drive(1'b1, 8'hC3, 1'b0, acc);
        idle(F + 2);

        drive(1'b1, 8'hB5, 1'b0, acc);
        idle(F + 2);

        pending = 1'b0;
        held    = '0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                drive(1'b0, '0, 1'b1, acc);
                pending = 1'b0;
            end else if (pending) begin
                drive(1'b1, held, 1'b0, acc);
                if (acc) pending = 1'b0;
            end else if ($urandom_range(0, 3) != 0) begin
                held = W'($urandom);
                drive(1'b1, held, 1'b0, acc);
                pending = !acc;
            end else begin
                drive(1'b0, W'($urandom), 1'b0, acc);
            end
        end

        idle(F + 3);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lab_06_serializer.md
Name: lab_06_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the lab 06 serial bit-stream sequence detector. It accepts a WIDTH-bit word through a valid/ready handshake and drives it one bit per clock onto the serial line `a` that feeds the detector. Back-to-back words stream with no idle gap, so the detector sees a continuous bit sequence.

Parameters:
WIDTH, 8, data word width in bits; legal range >= 2.
MSB_FIRST, 1, 1 = din[WIDTH-1] is shifted out first; 0 = din[0] is shifted out first.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
din  input  WIDTH  parallel word to serialize; sampled only on a handshake.
load_valid  input  1  producer has a word on din.
load_ready  output  1  serializer can accept a word this cycle.
a  output  1  serial data bit to the detector's `a` input; registered.
a_valid  output  1  `a` carries a frame bit this cycle; registered.
busy  output  1  a frame is in progress, i.e. state is SHIFT.
done  output  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- States: IDLE and SHIFT. Internal state: a WIDTH-bit shift register and a bit counter of $clog2(WIDTH+1) bits.
- Reset values, applied at the edge where reset=1 (reset has priority over everything):
  - state=IDLE, a=0, a_valid=0, done=0, busy=0, counter=0, shift register=0.
  - load_ready is 1 in the first cycle after reset.
- Handshake: a word is accepted at the rising edge where load_valid=1 and load_ready=1 (cycle T0). din is sampled only at that edge.
- load_ready is combinational. It is 1 when state=IDLE, or when state=SHIFT and the last bit of the frame is on `a`. Otherwise it is 0.
- Latency: for a word accepted at T0, bits appear on `a` in cycles T0+1 through T0+WIDTH with a_valid=1. Bit order follows MSB_FIRST.
- done=1 only in cycle T0+WIDTH. If no new word is accepted at that edge, the next cycle has state=IDLE, a_valid=0 and a=0.
- Back-to-back: a word accepted during the last-bit cycle puts its first bit on `a` in the very next cycle. There is no gap and a_valid stays 1.
- load_valid while load_ready=0 is ignored. It does not corrupt the frame and din is not captured; the producer must hold the word.
- Idle line level: when a_valid=0, `a` is 0.
- Reset mid-frame: the frame is aborted with no done pulse, and all outputs return to reset values in the next cycle.

Optional Feature:
Macro: LAB06_SER_PARITY_EN.
- When defined:
  - Each frame is WIDTH+1 bits: the data bits followed by one even-parity bit, equal to the XOR of all din bits.
  - done and the load_ready window move to the parity-bit cycle (T0+WIDTH+1).
  - The counter is sized $clog2(WIDTH+2).
- When undefined: frames are exactly WIDTH bits, with no parity logic or state.

Test Plan:
1. Single word: WIDTH=8, MSB_FIRST=1, din=8'hB4 accepted at T0.
   - `a` = 1,0,1,1,0,1,0,0 over T0+1..T0+8 with a_valid=1.
   - done=1 only at T0+8; a_valid=0 and a=0 at T0+9.
2. LSB-first: MSB_FIRST=0, din=8'hB4.
   - `a` = 0,0,1,0,1,1,0,1.
   - load_ready=0 from T0+1 through T0+7.
3. Back-to-back: 8'hFF at T0, load_valid held with din=8'h00.
   - The second word is accepted at T0+8.
   - `a` = eight 1s then eight 0s, a_valid continuously 1 from T0+1 to T0+16.
   - done at T0+8 and T0+16.
4. Load during busy: din=8'hA5 accepted at T0; at T0+3 drive load_valid=1 with din=8'h3C.
   - The 8'hA5 bits are unaltered and 8'h3C is not taken until the T0+8 edge.
5. Reset mid-frame: assert reset at T0+4 for one cycle.
   - At T0+5: a=0, a_valid=0, busy=0, done never pulses, load_ready=1.
   - A new word then serializes correctly.
6. Parity, with LAB06_SER_PARITY_EN defined: din=8'hB4 gives 9th bit 0; din=8'hB5 gives 9th bit 1. done is at T0+9.
